sc_level_sequencer: RTL and testbench

- Top-level game-flow controller for Frogger.
- Owns the level number and the per-level progress count that the level state machine consumes.
- Counts goal arrivals and lives, and inserts a timed freeze between levels.
- Publishes per-level obstacle speed to the lane generators, plus win and game-over flags to the display path.

---
 rtl/sc_level_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sc_level_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_level_sequencer.sv
// sc_level_sequencer: Frogger game-flow controller (level, progress, lives,
// inter-level freeze, per-level speed, win / game-over flags).
//
// Ports:
//   SC_LEVEL_SEQUENCER_CLOCK_50             in  system clock
//   SC_LEVEL_SEQUENCER_RESET_InLow          in  async active-low reset
//   SC_LEVEL_SEQUENCER_Start_In             in  start button level
//   SC_LEVEL_SEQUENCER_FrameTick_In         in  one pulse per frame
//   SC_LEVEL_SEQUENCER_Goal_In              in  frog reached top row
//   SC_LEVEL_SEQUENCER_Death_In             in  frog collision
//   SC_LEVEL_SEQUENCER_CurrentLevel_Out     out 0 idle, 1..3 play, 4 won
//   SC_LEVEL_SEQUENCER_LvlProgressCount_Out out goals in this level
//   SC_LEVEL_SEQUENCER_Lives_Out            out remaining lives
//   SC_LEVEL_SEQUENCER_Speed_Out            out lane speed divider
//   SC_LEVEL_SEQUENCER_Freeze_Out           out gameplay halted
//   SC_LEVEL_SEQUENCER_Win_Out              out game won
//   SC_LEVEL_SEQUENCER_GameOver_Out         out game lost
module sc_level_sequencer #(
  parameter int unsigned PROGRESS_TARGET  = 20,
  parameter int unsigned LIVES_INIT       = 3,
  parameter int unsigned TRANSITION_TICKS = 50,
  parameter logic [7:0]  SPEED_L1         = 8'd40,
  parameter logic [7:0]  SPEED_L2         = 8'd25,
  parameter logic [7:0]  SPEED_L3         = 8'd12
) (
  input  logic       SC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic       SC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic       SC_LEVEL_SEQUENCER_Start_In,
  input  logic       SC_LEVEL_SEQUENCER_FrameTick_In,
  input  logic       SC_LEVEL_SEQUENCER_Goal_In,
  input  logic       SC_LEVEL_SEQUENCER_Death_In,
  output logic [2:0] SC_LEVEL_SEQUENCER_CurrentLevel_Out,
  output logic [4:0] SC_LEVEL_SEQUENCER_LvlProgressCount_Out,
  output logic [1:0] SC_LEVEL_SEQUENCER_Lives_Out,
  output logic [7:0] SC_LEVEL_SEQUENCER_Speed_Out,
  output logic       SC_LEVEL_SEQUENCER_Freeze_Out,
  output logic       SC_LEVEL_SEQUENCER_Win_Out,
  output logic       SC_LEVEL_SEQUENCER_GameOver_Out
);

  localparam logic [4:0] ProgTarget = 5'(PROGRESS_TARGET);
  localparam logic [1:0] LivesInit  = 2'(LIVES_INIT);
  localparam logic [7:0] TransTicks = 8'(TRANSITION_TICKS);

  typedef enum logic [2:0] {
    stIdle       = 3'd0,
    stPlay       = 3'd1,
    stTransition = 3'd2,
    stWin        = 3'd3,
    stGameOver   = 3'd4
  } state_t;

  state_t     state, stateNext;
  logic [2:0] level, levelNext;
  logic [4:0] progress, progressNext;
  logic [1:0] lives, livesNext;
  logic [7:0] speed, speedNext;
  logic [7:0] transCount, transCountNext;
  logic       freeze, freezeNext;
  logic       win, winNext;
  logic       gameOver, gameOverNext;
  logic       startQ;

  logic       clk;
  logic       rstN;
  logic       startEvent;
  logic       goal;
  logic       death;
  logic       frameTick;
  logic [4:0] progressInc;
  logic [7:0] transInc;

  assign clk        = SC_LEVEL_SEQUENCER_CLOCK_50;
  assign rstN       = SC_LEVEL_SEQUENCER_RESET_InLow;
  assign goal       = SC_LEVEL_SEQUENCER_Goal_In;
  assign death      = SC_LEVEL_SEQUENCER_Death_In;
  assign frameTick  = SC_LEVEL_SEQUENCER_FrameTick_In;
  assign startEvent = SC_LEVEL_SEQUENCER_Start_In & ~startQ;

  assign progressInc = progress + 5'd1;
  assign transInc    = transCount + 8'd1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= stIdle;
      level      <= 3'd0;
      progress   <= 5'd0;
      lives      <= LivesInit;
      speed      <= 8'd0;
      transCount <= 8'd0;
      freeze     <= 1'b1;
      win        <= 1'b0;
      gameOver   <= 1'b0;
      startQ     <= 1'b0;
    end else begin
      state      <= stateNext;
      level      <= levelNext;
      progress   <= progressNext;
      lives      <= livesNext;
      speed      <= speedNext;
      transCount <= transCountNext;
      freeze     <= freezeNext;
      win        <= winNext;
      gameOver   <= gameOverNext;
      startQ     <= SC_LEVEL_SEQUENCER_Start_In;
    end
  end

  always_comb begin
    stateNext      = state;
    levelNext      = level;
    progressNext   = progress;
    livesNext      = lives;
    speedNext      = speed;
    transCountNext = transCount;

    case (state)
      stIdle: begin
        if (startEvent) begin
          stateNext    = stPlay;
          levelNext    = 3'd1;
          progressNext = 5'd0;
          livesNext    = LivesInit;
          speedNext    = SPEED_L1;
        end
      end

      stPlay: begin
        // Death wins over a coincident goal.
        if (death) begin
          if (lives > 2'd1) begin
            livesNext = lives - 2'd1;
          end else begin
            livesNext = 2'd0;
            stateNext = stGameOver;
          end
        end else if (goal && progress < ProgTarget) begin
          progressNext = progressInc;
          if (progressInc == ProgTarget) begin
            if (level < 3'd3) begin
              stateNext      = stTransition;
              transCountNext = 8'd0;
            end else begin
              stateNext = stWin;
              levelNext = 3'd4;
            end
          end
        end
      end

      stTransition: begin
        if (frameTick) begin
          transCountNext = transInc;
          if (transInc == TransTicks) begin
            stateNext    = stPlay;
            levelNext    = level + 3'd1;
            progressNext = 5'd0;
            speedNext    = (level == 3'd1) ? SPEED_L2 : SPEED_L3;
          end
        end
      end

      stWin, stGameOver: begin
        if (startEvent) begin
          stateNext      = stIdle;
          levelNext      = 3'd0;
          progressNext   = 5'd0;
          livesNext      = LivesInit;
          speedNext      = 8'd0;
          transCountNext = 8'd0;
        end
      end

      default: begin
        stateNext      = stIdle;
        levelNext      = 3'd0;
        progressNext   = 5'd0;
        livesNext      = LivesInit;
        speedNext      = 8'd0;
        transCountNext = 8'd0;
      end
    endcase

    // Flags follow the state being entered so they land with it.
    freezeNext   = (stateNext != stPlay);
    winNext      = (stateNext == stWin);
    gameOverNext = (stateNext == stGameOver);
  end

  assign SC_LEVEL_SEQUENCER_CurrentLevel_Out     = level;
  assign SC_LEVEL_SEQUENCER_LvlProgressCount_Out = progress;
  assign SC_LEVEL_SEQUENCER_Lives_Out            = lives;
  assign SC_LEVEL_SEQUENCER_Speed_Out            = speed;
  assign SC_LEVEL_SEQUENCER_Freeze_Out           = freeze;
  assign SC_LEVEL_SEQUENCER_Win_Out              = win;
  assign SC_LEVEL_SEQUENCER_GameOver_Out         = gameOver;

endmodule

// File: tb/tb_sc_level_sequencer.sv
// tb_sc_level_sequencer: directed stimulus against a game-rule model,
// compared on every falling edge plus literal spot checks.
module tb_sc_level_sequencer;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       ft;
  logic       goal;
  logic       death;
  logic [2:0] level;
  logic [4:0] prog;
  logic [1:0] lives;
  logic [7:0] speed;
  logic       freeze;
  logic       win;
  logic       over;

  int errors;
  int checks;
  bit chkEn;

  // Model: mode 0 idle, 1 play, 2 between levels, 3 won, 4 lost.
  int mMode;
  int mLevel;
  int mProg;
  int mLives;
  int mSpeed;
  int mCnt;
  bit mStartQ;
  int spdTab[4] = '{0, 40, 25, 12};

  sc_level_sequencer dut (
    .SC_LEVEL_SEQUENCER_CLOCK_50(clk),
    .SC_LEVEL_SEQUENCER_RESET_InLow(rstN),
    .SC_LEVEL_SEQUENCER_Start_In(start),
    .SC_LEVEL_SEQUENCER_FrameTick_In(ft),
    .SC_LEVEL_SEQUENCER_Goal_In(goal),
    .SC_LEVEL_SEQUENCER_Death_In(death),
    .SC_LEVEL_SEQUENCER_CurrentLevel_Out(level),
    .SC_LEVEL_SEQUENCER_LvlProgressCount_Out(prog),
    .SC_LEVEL_SEQUENCER_Lives_Out(lives),
    .SC_LEVEL_SEQUENCER_Speed_Out(speed),
    .SC_LEVEL_SEQUENCER_Freeze_Out(freeze),
    .SC_LEVEL_SEQUENCER_Win_Out(win),
    .SC_LEVEL_SEQUENCER_GameOver_Out(over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mLevel = 0; mProg = 0; mLives = 3;
    mSpeed = 0; mCnt = 0; mStartQ = 1'b0;
  endtask

  task automatic modelStep();
    bit ev;
    if (!rstN) begin
      modelReset();
      return;
    end
    ev = start && !mStartQ;
    mStartQ = start;
    case (mMode)
      0: if (ev) begin
        mMode = 1; mLevel = 1; mProg = 0;
        mLives = 3; mSpeed = spdTab[1];
      end
      1: if (death) begin
        mLives = (mLives > 1) ? mLives - 1 : 0;
        if (mLives == 0) mMode = 4;
      end else if (goal) begin
        mProg++;
        if (mProg == 20) begin
          if (mLevel < 3) begin
            mMode = 2; mCnt = 0;
          end else begin
            mMode = 3; mLevel = 4;
          end
        end
      end
      2: if (ft) begin
        mCnt++;
        if (mCnt == 50) begin
          mMode = 1; mLevel++; mProg = 0;
          mSpeed = spdTab[mLevel];
        end
      end
      default: if (ev) begin
        mMode = 0; mLevel = 0; mProg = 0;
        mLives = 3; mSpeed = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      cmp("level", int'(level), mLevel);
      cmp("progress", int'(prog), mProg);
      cmp("lives", int'(lives), mLives);
      cmp("speed", int'(speed), mSpeed);
      cmp("freeze", int'(freeze), int'(mMode != 1));
      cmp("win", int'(win), int'(mMode == 3));
      cmp("gameover", int'(over), int'(mMode == 4));
    end
  end

  task automatic tick(input logic f, input logic g, input logic d);
    ft = f; goal = g; death = d;
    @(posedge clk);
    modelStep();
    #1;
    ft = 1'b0; goal = 1'b0; death = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic goals(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic startEdge();
    start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0; checks = 0; chkEn = 1'b0;
    rstN = 1'b0; start = 1'b0;
    ft = 1'b0; goal = 1'b0; death = 1'b0;
    modelReset();
    #1;
    chkEn = 1'b1;
    idle(3);
    rstN = 1'b1;
    idle(10);
    cmp("idle level", int'(level), 0);
    cmp("idle lives", int'(lives), 3);
    cmp("idle freeze", int'(freeze), 1);

    // Held start: one entry only
    start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    cmp("start level", int'(level), 1);
    cmp("start speed", int'(speed), 40);
    cmp("start freeze", int'(freeze), 0);
    for (int i = 0; i < 19; i++) tick(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    idle(2);

    // Level 1 -> 2, goals/deaths ignored while frozen
    goals(20);
    cmp("l1 done prog", int'(prog), 20);
    cmp("l1 done freeze", int'(freeze), 1);
    goals(3);
    tick(1'b0, 1'b0, 1'b1);
    cmp("frozen prog", int'(prog), 20);
    cmp("frozen lives", int'(lives), 3);
    frames(49);
    cmp("49 ticks level", int'(level), 1);
    frames(1);
    cmp("l2 level", int'(level), 2);
    cmp("l2 prog", int'(prog), 0);
    cmp("l2 speed", int'(speed), 25);
    cmp("l2 freeze", int'(freeze), 0);

    // Levels 2 and 3 -> win
    goals(20);
    frames(50);
    cmp("l3 speed", int'(speed), 12);
    goals(19);
    cmp("l3 19 win", int'(win), 0);
    goals(1);
    cmp("win level", int'(level), 4);
    cmp("win flag", int'(win), 1);
    cmp("win freeze", int'(freeze), 1);
    idle(3);
    startEdge();
    cmp("post-win level", int'(level), 0);
    cmp("post-win speed", int'(speed), 0);
    cmp("post-win win", int'(win), 0);

    // Deaths and goal/death collision
    startEdge();
    goals(5);
    tick(1'b0, 1'b1, 1'b1);
    cmp("collide lives", int'(lives), 2);
    cmp("collide prog", int'(prog), 5);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    cmp("over lives", int'(lives), 0);
    cmp("over flag", int'(over), 1);
    cmp("over level", int'(level), 1);
    tick(1'b0, 1'b1, 1'b1);
    idle(2);
    startEdge();
    cmp("post-over flag", int'(over), 0);

    // Async reset mid-transition
    startEdge();
    goals(20);
    frames(10);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    cmp("async level", int'(level), 0);
    cmp("async prog", int'(prog), 0);
    cmp("async lives", int'(lives), 3);
    cmp("async freeze", int'(freeze), 1);
    idle(2);
    rstN = 1'b1;
    frames(60);
    cmp("needs start", int'(level), 0);
    startEdge();
    cmp("restart level", int'(level), 1);
    idle(2);

    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
